// File: rtl/vga_pkg.sv
// Shared constants for the 640x480 @ 60 Hz raster timing path.
// Default porch/sync widths, totals and coordinate widths.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int D_WIDTH   = 640;
  localparam int D_H_FRONT = 16;
  localparam int D_H_SYNC  = 96;
  localparam int D_H_BACK  = 48;

  localparam int D_HEIGHT  = 480;
  localparam int D_V_FRONT = 10;
  localparam int D_V_SYNC  = 2;
  localparam int D_V_BACK  = 33;

  localparam int D_H_TOTAL =
    D_WIDTH + D_H_FRONT + D_H_SYNC + D_H_BACK;
  localparam int D_V_TOTAL =
    D_HEIGHT + D_V_FRONT + D_V_SYNC + D_V_BACK;

  typedef logic [CNT_W-1:0] cnt_t;

  // Sum of the four segments of one axis.
  function automatic int axis_total(
    input int vis,
    input int front,
    input int sync,
    input int back
  );
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N counter for one raster axis.
// Advances when enabled; o_wrap marks the N-1 -> 0 step.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int N = 800
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  // Terminal count detection
  always_comb begin
    w_last = (r_count == CNT_W'(N - 1));
  end

  // Count register, wraps to zero after N-1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_last) r_count <= '0;
      else        r_count <= r_count + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    o_count = r_count;
    o_wrap  = i_en & w_last;
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing for the VGA display path on the pixel clock.
// Sync, active and end-of-frame are decoded from two counters.
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter int WIDTH   = D_WIDTH,
  parameter int HEIGHT  = D_HEIGHT,
  parameter int H_FRONT = D_H_FRONT,
  parameter int H_SYNC  = D_H_SYNC,
  parameter int H_BACK  = D_H_BACK,
  parameter int V_FRONT = D_V_FRONT,
  parameter int V_SYNC  = D_V_SYNC,
  parameter int V_BACK  = D_V_BACK
) (
  input  logic           clk25,
  input  logic           reset,
  output logic           hSync,
  output logic           vSync,
  output logic           active,
  output logic           screenEnd,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam int H_TOTAL =
    axis_total(WIDTH, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    axis_total(HEIGHT, V_FRONT, V_SYNC, V_BACK);

  localparam int HS_BEG = WIDTH + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = HEIGHT + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;

  // Totals above CNT_MAX would alias inside the 10-bit counters.
  localparam bit SIZE_OK =
    (H_TOTAL <= CNT_MAX) && (V_TOTAL <= CNT_MAX);

  cnt_t w_h_count;
  cnt_t w_v_count;
  logic w_h_wrap;
  logic w_v_wrap_unused;
  logic w_h_vis;
  logic w_v_vis;
  logic w_h_sync;
  logic w_v_sync;

  vga_axis_counter #(
    .N (H_TOTAL)
  ) u_h_cnt (
    .i_clk   (clk25),
    .i_rst_n (reset),
    .i_en    (1'b1),
    .o_count (w_h_count),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(
    .N (V_TOTAL)
  ) u_v_cnt (
    .i_clk   (clk25),
    .i_rst_n (reset),
    .i_en    (w_h_wrap),
    .o_count (w_v_count),
    .o_wrap  (w_v_wrap_unused)
  );

  // Region decode on the raw counters
  always_comb begin
    w_h_vis  = (w_h_count < CNT_W'(WIDTH));
    w_v_vis  = (w_v_count < CNT_W'(HEIGHT));
    w_h_sync = (w_h_count >= CNT_W'(HS_BEG)) &&
               (w_h_count <  CNT_W'(HS_END));
    w_v_sync = (w_v_count >= CNT_W'(VS_BEG)) &&
               (w_v_count <  CNT_W'(VS_END));
  end

  // Output decode; zero latency from counter state
  always_comb begin
    active    = w_h_vis & w_v_vis;
    hSync     = ~w_h_sync;
    vSync     = ~w_v_sync;
    screenEnd = (w_h_count == '0) &&
                (w_v_count == CNT_W'(HEIGHT));
    x         = w_h_count[X_W-1:0];
    y         = w_v_count[Y_W-1:0];
  end

  if (!SIZE_OK) begin : g_size_bad
    $error("vga_timing_generator: total exceeds counter range");
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: default 640x480
// instance for line timing, a tiny instance for frame timing.
module tb_vga_timing_generator;

  logic       clk25;
  logic       rst_d;
  logic       rst_s;

  logic       hs_d, vs_d, act_d, se_d;
  logic [9:0] x_d;
  logic [8:0] y_d;

  logic       hs_s, vs_s, act_s, se_s;
  logic [9:0] x_s;
  logic [8:0] y_s;

  int total;
  int bad;

  vga_timing_generator u_dut (
    .clk25     (clk25),
    .reset     (rst_d),
    .hSync     (hs_d),
    .vSync     (vs_d),
    .active    (act_d),
    .screenEnd (se_d),
    .x         (x_d),
    .y         (y_d)
  );

  // Tiny raster: H 8+2+3+2=15, V 6+1+2+1=10, frame 150.
  vga_timing_generator #(
    .WIDTH   (8),
    .HEIGHT  (6),
    .H_FRONT (2),
    .H_SYNC  (3),
    .H_BACK  (2),
    .V_FRONT (1),
    .V_SYNC  (2),
    .V_BACK  (1)
  ) u_small (
    .clk25     (clk25),
    .reset     (rst_s),
    .hSync     (hs_s),
    .vSync     (vs_s),
    .active    (act_s),
    .screenEnd (se_s),
    .x         (x_s),
    .y         (y_s)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic step(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic restart_d();
    @(negedge clk25);
    rst_d = 1'b0;
    step(2);
    rst_d = 1'b1;
  endtask

  task automatic restart_s();
    @(negedge clk25);
    rst_s = 1'b0;
    step(2);
    rst_s = 1'b1;
  endtask

  task automatic test_reset();
    rst_d = 1'b0;
    rst_s = 1'b0;
    step(3);
    total++;
    if ({x_d, y_d} !== 19'd0) begin
      bad++;
      $display("FAIL reset_xy got x=%0d y=%0d want 0 0",
               x_d, y_d);
    end
    total++;
    if ({act_d, hs_d, vs_d, se_d} !== 4'b1110) begin
      bad++;
      $display("FAIL reset_flags got %b want 1110",
               {act_d, hs_d, vs_d, se_d});
    end
    rst_d = 1'b1;
    total++;
    if (x_d !== 10'd0) begin
      bad++;
      $display("FAIL release_x got %0d want 0", x_d);
    end
    step(1);
    total++;
    if (x_d !== 10'd1) begin
      bad++;
      $display("FAIL first_edge_x got %0d want 1", x_d);
    end
  endtask

  task automatic test_hsync();
    restart_d();
    step(655);
    total++;
    if (x_d !== 10'd655 || hs_d !== 1'b1) begin
      bad++;
      $display("FAIL hs_655 got x=%0d hs=%b want 655 1",
               x_d, hs_d);
    end
    step(1);
    total++;
    if (x_d !== 10'd656 || hs_d !== 1'b0) begin
      bad++;
      $display("FAIL hs_656 got x=%0d hs=%b want 656 0",
               x_d, hs_d);
    end
    step(95);
    total++;
    if (x_d !== 10'd751 || hs_d !== 1'b0) begin
      bad++;
      $display("FAIL hs_751 got x=%0d hs=%b want 751 0",
               x_d, hs_d);
    end
    step(1);
    total++;
    if (x_d !== 10'd752 || hs_d !== 1'b1) begin
      bad++;
      $display("FAIL hs_752 got x=%0d hs=%b want 752 1",
               x_d, hs_d);
    end
  endtask

  task automatic test_line();
    int hs_low;
    int overlap;
    hs_low = 0;
    overlap = 0;
    restart_d();
    for (int k = 1; k <= 799; k++) begin
      step(1);
      if (!hs_d) hs_low++;
      if (act_d && !hs_d) overlap++;
      if (k == 639) begin
        total++;
        if (act_d !== 1'b1 || x_d !== 10'd639) begin
          bad++;
          $display("FAIL act_639 got x=%0d act=%b want 639 1",
                   x_d, act_d);
        end
      end
      if (k == 640) begin
        total++;
        if (act_d !== 1'b0 || x_d !== 10'd640) begin
          bad++;
          $display("FAIL act_640 got x=%0d act=%b want 640 0",
                   x_d, act_d);
        end
      end
    end
    total++;
    if (x_d !== 10'd799 || y_d !== 9'd0) begin
      bad++;
      $display("FAIL line_end got x=%0d y=%0d want 799 0",
               x_d, y_d);
    end
    step(1);
    total++;
    if (x_d !== 10'd0 || y_d !== 9'd1 || act_d !== 1'b1) begin
      bad++;
      $display("FAIL line_wrap got x=%0d y=%0d act=%b want 0 1 1",
               x_d, y_d, act_d);
    end
    total++;
    if (hs_low !== 96) begin
      bad++;
      $display("FAIL hs_width got %0d want 96", hs_low);
    end
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("FAIL line_overlap got %0d want 0", overlap);
    end
  endtask

  task automatic test_async_reset();
    restart_d();
    step(1500);
    total++;
    if (x_d !== 10'd700 || y_d !== 9'd1 || hs_d !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset got x=%0d y=%0d hs=%b want 700 1 0",
               x_d, y_d, hs_d);
    end
    @(posedge clk25);
    #7;
    rst_d = 1'b0;
    #1;
    total++;
    if (x_d !== 10'd0 || y_d !== 9'd0 ||
        hs_d !== 1'b1 || act_d !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got x=%0d y=%0d hs=%b act=%b want 0 0 1 1",
               x_d, y_d, hs_d, act_d);
    end
    step(1);
    rst_d = 1'b1;
  endtask

  task automatic test_vsync();
    int vs_low;
    int fall_h;
    int fall_v;
    logic prev;
    vs_low = 0;
    fall_h = -1;
    fall_v = -1;
    restart_s();
    prev = vs_s;
    for (int k = 1; k <= 150; k++) begin
      step(1);
      if (!vs_s) vs_low++;
      if (prev && !vs_s) begin
        fall_h = int'(x_s);
        fall_v = int'(y_s);
      end
      prev = vs_s;
    end
    total++;
    if (vs_low !== 30) begin
      bad++;
      $display("FAIL vs_width got %0d want 30", vs_low);
    end
    total++;
    if (fall_h !== 0 || fall_v !== 7) begin
      bad++;
      $display("FAIL vs_fall got h=%0d v=%0d want 0 7",
               fall_h, fall_v);
    end
  endtask

  task automatic test_screen_end();
    int n;
    int first;
    int gap_bad;
    int wide;
    int last;
    logic prev;
    n = 0;
    first = -1;
    gap_bad = 0;
    wide = 0;
    last = -1;
    restart_s();
    total++;
    if (se_s !== 1'b0) begin
      bad++;
      $display("FAIL se_at_release got %b want 0", se_s);
    end
    prev = 1'b0;
    for (int k = 1; k <= 460; k++) begin
      step(1);
      if (se_s) begin
        n++;
        if (prev) wide++;
        if (first < 0) first = k;
        else if (k - last != 150) gap_bad++;
        last = k;
      end
      prev = se_s;
    end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL se_count got %0d want 3", n);
    end
    total++;
    if (first !== 90) begin
      bad++;
      $display("FAIL se_first got %0d want 90", first);
    end
    total++;
    if (gap_bad !== 0 || wide !== 0) begin
      bad++;
      $display("FAIL se_spacing got gap_bad=%0d wide=%0d want 0 0",
               gap_bad, wide);
    end
  endtask

  task automatic test_active_frame();
    int act_n;
    int overlap;
    act_n = 0;
    overlap = 0;
    restart_s();
    for (int k = 1; k <= 150; k++) begin
      step(1);
      if (act_s) act_n++;
      if (act_s && (!hs_s || !vs_s)) overlap++;
      if (k == 149) begin
        total++;
        if (x_s !== 10'd14 || y_s !== 9'd9 || act_s !== 1'b0) begin
          bad++;
          $display("FAIL frame_last got x=%0d y=%0d act=%b want 14 9 0",
                   x_s, y_s, act_s);
        end
      end
    end
    total++;
    if (x_s !== 10'd0 || y_s !== 9'd0 || act_s !== 1'b1) begin
      bad++;
      $display("FAIL frame_wrap got x=%0d y=%0d act=%b want 0 0 1",
               x_s, y_s, act_s);
    end
    total++;
    if (act_n !== 48) begin
      bad++;
      $display("FAIL active_count got %0d want 48", act_n);
    end
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("FAIL frame_overlap got %0d want 0", overlap);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_d = 1'b0;
    rst_s = 1'b0;
    test_reset();
    test_hsync();
    test_line();
    test_async_reset();
    test_vsync();
    test_screen_end();
    test_active_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Raster timing generator for the 640×480 @ 60 Hz VGA display path. It runs on the 25 MHz pixel clock and produces:
- horizontal and vertical sync,
- an active-video flag,
- the current pixel coordinate,
- a one-cycle end-of-frame strobe.

The display controller uses the coordinate to address image/palette memory and blank colour. It uses the strobe to tell the processor when dot positions may be updated.

## Interface
Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines per frame
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk25  in  1  pixel clock (25 MHz); one clock domain
- reset  in  1  asynchronous, active-low reset
- hSync  out  1  horizontal sync, active-low
- vSync  out  1  vertical sync, active-low
- active  out  1  high while (x, y) is inside the visible WIDTH×HEIGHT area
- screenEnd  out  1  one-cycle strobe at the start of vertical blanking
- x  out  10  horizontal coordinate from left
- y  out  9  vertical coordinate from top

## Operation
- Internal counters:
  - hCount: 10 bits, range 0..H_TOTAL-1, where H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK = 800.
  - vCount: 10 bits, range 0..V_TOTAL-1, where V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK = 525.
- hCount increments every clk25 and wraps from H_TOTAL-1 to 0.
- vCount increments only when hCount wraps, and wraps from V_TOTAL-1 to 0 on that same edge.
- active = (hCount < WIDTH) && (vCount < HEIGHT).
- hSync = 0 iff WIDTH+H_FRONT ≤ hCount < WIDTH+H_FRONT+H_SYNC, i.e. 656..751.
- vSync = 0 iff HEIGHT+V_FRONT ≤ vCount < HEIGHT+V_FRONT+V_SYNC, i.e. 490..491.
- screenEnd = 1 iff hCount == 0 && vCount == HEIGHT (480): exactly one cycle per frame.
- x = hCount[9:0]; y = vCount[8:0]. Both are meaningful only while active. During blanking they carry raw count bits, so y aliases for vCount ≥ 512, and consumers must gate on active.
- Sizing: counters cover up to 1023, so all parameter sets must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.

## Timing
- Counters are registered on the rising edge of clk25. All outputs are combinational decodes of the counters, so they have zero latency relative to the counter state.
- Reset is asserted (reset = 0), asynchronously: hCount = vCount = 0. Outputs during reset are x=0, y=0, active=1, hSync=1, vSync=1, screenEnd=0.
- On reset release, the first rising edge advances hCount to 1.
- Reset mid-frame immediately restarts at pixel (0,0). No partial-line recovery.
- Line period is 800 clocks; frame period is 420 000 clocks.
- hSync low for 96 clocks per line. vSync low for 1600 clocks per frame, aligned to hCount = 0.
- At the line/frame wrap (hCount = 799, vCount = 524), the next edge gives hCount = 0, vCount = 0, and active rises.

## Structure
- Shared package `vga_pkg`:
  - default 640×480 timing constants (widths, porches, sync widths, totals);
  - coordinate widths (X_W = 10, Y_W = 9).
- One natural sub-module, `vga_axis_counter`, instantiated twice:
  - a modulo-N counter with enable, asynchronous active-low reset, and a wrap output;
  - the horizontal instance is always enabled;
  - the vertical instance is enabled by the horizontal wrap.
- Sync and active decoding lives in the top module.

## Test plan
- Reset held low, then released → x=0, y=0, active=1, hSync=1, vSync=1. After 655 edges x=655 with hSync=1; after 656 edges hSync=0. hSync returns to 1 at x=752.
- Run one full line → active falls at x=640; at the edge after x=799, x=0 and y=1.
- Run to vCount 490 → vSync=0 for exactly 2 lines (1600 clocks). Its falling edge coincides with hCount=0.
- Count screenEnd pulses over 3 frames → exactly 3 pulses, each one cycle wide, spaced 420 000 clocks, first at 384 000 clocks after reset release.
- Assert reset asynchronously mid-frame (e.g. x=300, y=200, between edges) → x/y/sync snap to reset values without waiting for a clock edge.
- Check active over a full frame → exactly 307 200 active cycles per frame. active is never high while hSync or vSync is low.
